tag_nway: RTL and testbench
===========================

Name: tag_nway

Overview:
- Parametrised N-way set-associative cache tag store. Successor to the single-way 1r1w tag RAM.
- Holds tag, valid and dirty bits for every way of every set. Performs a registered tag lookup with hit/way detection and picks a victim way by round-robin.
- Runs a set-sweep state machine that invalidates the whole array after reset or on a flush request.
- Sits in the IF/MA stage beside the data RAM of the I-cache or D-cache; the cache controller drives it.

Parameters:
- DRWIDTH, 9: set index width; 2**DRWIDTH sets.
- TAGW, 15: tag width. Default equals 24-DRWIDTH.
- WAYBITS, 1: way-select width; WAYS = 2**WAYBITS. Legal values 1..2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- lkup_en  in  1  lookup request.
- lkup_idx  in  DRWIDTH  lookup set index.
- lkup_tag  in  TAGW  lookup compare tag.
- lkup_vld  out  1  lookup result valid; high one cycle after an accepted lkup_en.
- hit  out  1  a valid way's tag matches lkup_tag.
- hit_way  out  WAYBITS  matching way.
- victim_way  out  WAYBITS  replacement candidate for the looked-up set.
- victim_valid  out  1  valid bit of victim_way.
- victim_dirty  out  1  dirty bit of victim_way.
- victim_tag  out  TAGW  stored tag of victim_way, used for write-back address.
- wr_en  in  1  fill write.
- wr_idx  in  DRWIDTH  fill set index.
- wr_way  in  WAYBITS  fill way.
- wr_tag  in  TAGW  fill tag.
- wr_dirty  in  1  dirty value on fill.
- dset_en  in  1  set the dirty bit of an existing entry.
- dset_idx  in  DRWIDTH  set index for dset_en.
- dset_way  in  WAYBITS  way for dset_en.
- flush_req  in  1  pulse; invalidate all sets.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to SWEEP, sweep counter = 0, busy = 1, lkup_vld = 0, hit = 0. hit_way, victim_* and all other registered outputs = 0. Array contents need no reset; the sweep clears them.
- FSM states are SWEEP and IDLE.
  - SWEEP: each cycle writes set[counter] with every way valid = 0, dirty = 0, and that set's round-robin pointer = 0; counter then increments.
  - SWEEP → IDLE in the cycle after the write to set 2**DRWIDTH-1. The sweep therefore takes exactly 2**DRWIDTH cycles, and busy drops on the following edge.
  - IDLE → SWEEP when flush_req = 1; counter = 0 and busy = 1 from the next cycle.
  - flush_req while in SWEEP: ignored, with no restart.
  - rst_n asserted mid-sweep: restarts the sweep from set 0.
- While busy = 1: lkup_en, wr_en and dset_en are ignored, and lkup_vld stays 0.
- Lookup latency is 1. On the edge where lkup_en is accepted, the set index is registered. In the next cycle lkup_vld = 1 and hit / hit_way / victim_* are valid for that set.
  - Outputs other than lkup_vld hold their value until the next accepted lookup.
- Hit rule: way w hits when valid[w] = 1 and tag[w] == lkup_tag, using the lkup_tag registered with the request.
  - Multiple hits are a contract violation; if they occur, the lowest-numbered hitting way is reported.
  - No hit: hit = 0, hit_way = 0.
- Victim rule: the lowest-numbered invalid way if any way is invalid; otherwise the set's round-robin pointer.
- Round-robin pointer: on an accepted wr_en, the pointer of set wr_idx becomes wr_way+1, modulo WAYS (wraps to 0).
- Fill: wr_en writes tag = wr_tag, valid = 1, dirty = wr_dirty into (wr_idx, wr_way).
- Dirty set: dset_en sets dirty = 1 at (dset_idx, dset_way); tag and valid are unchanged. Setting dirty on an invalid entry is allowed but has no meaning.
- Simultaneous wr_en and dset_en on the same idx/way: wr_en wins, and dirty = wr_dirty.
- Lookup in the same cycle as a write to the same set is write-first: the result reflects the new contents.
- A flush while dirty lines exist discards them. The controller must write back dirty lines before pulsing flush_req.

Test Plan:
- Reset, DRWIDTH=4, WAYBITS=1 → busy = 1 for exactly 16 cycles, then 0. A lookup of idx 3 then gives hit = 0, victim_way = 0, victim_valid = 0.
- Fill idx 5 way 0 with tag 0x1A3, then lookup idx 5 tag 0x1A3 → lkup_vld one cycle later, hit = 1, hit_way = 0, victim_way = 1 (invalid way).
- Fill idx 5 way 1 with tag 0x022 and wr_dirty = 1, then lookup idx 5 tag 0x7FF → hit = 0, victim_way = 0 (pointer = (1+1) mod 2), victim_valid = 1, victim_tag = 0x1A3, victim_dirty = 0.
- dset_en on idx 5 way 0 in the same cycle as wr_en on idx 5 way 0 with wr_dirty = 0 and tag 0x055 → the next lookup of tag 0x055 gives hit = 1 with dirty = 0, via victim_dirty when way 0 is the victim.
- Lookup of idx 7 in the same cycle as a fill of idx 7 way 1 with tag 0x0AA, lookup tag 0x0AA → hit = 1, hit_way = 1 (write-first).
- flush_req after the fills, with lkup_en held high → lkup_vld = 0 for 16 cycles. After that, a lookup of idx 5 tag 0x1A3 gives hit = 0, victim_way = 0. Assert rst_n at sweep cycle 8 → busy lasts a full 16 cycles from release.

Source files
------------

// File: rtl/tag_nway.sv
// N-way set-associative tag store. It does a registered lookup with hit/way detection and round-robin victim selection.
// A set sweep invalidates every set after reset or on a flush request.
module tag_nway #(
  parameter int DRWIDTH = 9,
  parameter int TAGW    = 15,
  parameter int WAYBITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lkup_en,
  input  logic [DRWIDTH-1:0] lkup_idx,
  input  logic [TAGW-1:0]    lkup_tag,
  output logic               lkup_vld,
  output logic               hit,
  output logic [WAYBITS-1:0] hit_way,
  output logic [WAYBITS-1:0] victim_way,
  output logic               victim_valid,
  output logic               victim_dirty,
  output logic [TAGW-1:0]    victim_tag,
  input  logic               wr_en,
  input  logic [DRWIDTH-1:0] wr_idx,
  input  logic [WAYBITS-1:0] wr_way,
  input  logic [TAGW-1:0]    wr_tag,
  input  logic               wr_dirty,
  input  logic               dset_en,
  input  logic [DRWIDTH-1:0] dset_idx,
  input  logic [WAYBITS-1:0] dset_way,
  input  logic               flush_req,
  output logic               busy
);

  localparam int WAYS = 1 << WAYBITS;
  localparam int SETS = 1 << DRWIDTH;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DRWIDTH-1:0] cnt_q, cnt_d;

  logic               lkup_vld_q, lkup_vld_d;
  logic               hit_q, hit_d;
  logic [WAYBITS-1:0] hit_way_q, hit_way_d;
  logic [WAYBITS-1:0] victim_way_q, victim_way_d;
  logic               victim_valid_q, victim_valid_d;
  logic               victim_dirty_q, victim_dirty_d;
  logic [TAGW-1:0]    victim_tag_q, victim_tag_d;

  logic               sweep_we;
  logic               lkup_acc;
  logic               wr_acc;
  logic               dset_acc;

  logic [WAYS-1:0]    valid_mem [SETS];
  logic [WAYS-1:0]    dirty_mem [SETS];
  logic [WAYBITS-1:0] rr_mem    [SETS];

  logic [TAGW-1:0]    rd_tag  [WAYS];
  logic [TAGW-1:0]    eff_tag [WAYS];
  logic [WAYS-1:0]    rd_valid, rd_dirty;
  logic [WAYS-1:0]    eff_valid, eff_dirty;
  logic [WAYS-1:0]    hit_vec;
  logic [WAYBITS-1:0] rr_eff;

  logic               look_hit;
  logic [WAYBITS-1:0] look_hit_way;
  logic [WAYBITS-1:0] look_victim;

  assign busy     = (state_q == ST_SWEEP);
  assign sweep_we = (state_q == ST_SWEEP);
  assign lkup_acc = lkup_en && !busy;
  assign wr_acc   = wr_en   && !busy;
  assign dset_acc = dset_en && !busy;

  // Sweep controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + DRWIDTH'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-set state; when a fill and a dirty-set hit the same entry, the later fill assignment wins.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      valid_mem[cnt_q] <= '0;
      dirty_mem[cnt_q] <= '0;
      rr_mem[cnt_q]    <= '0;
    end else begin
      if (dset_acc) begin
        dirty_mem[dset_idx][dset_way] <= 1'b1;
      end
      if (wr_acc) begin
        valid_mem[wr_idx][wr_way] <= 1'b1;
        dirty_mem[wr_idx][wr_way] <= wr_dirty;
        rr_mem[wr_idx]            <= wr_way + WAYBITS'(1);
      end
    end
  end

  assign rd_valid = valid_mem[lkup_idx];
  assign rd_dirty = dirty_mem[lkup_idx];
  assign rr_eff   = (wr_acc && (wr_idx == lkup_idx)) ? (wr_way + WAYBITS'(1))
                                                     : rr_mem[lkup_idx];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAGW-1:0] tag_mem [SETS];
    logic            wr_here;
    logic            dset_here;

    always_ff @(posedge clk) begin
      if (wr_acc && (wr_way == WAYBITS'(gi))) begin
        tag_mem[wr_idx] <= wr_tag;
      end
    end

    // Forward a same-cycle write to the looked-up set so the lookup sees the new contents.
    assign wr_here   = wr_acc && (wr_idx == lkup_idx) && (wr_way == WAYBITS'(gi));
    assign dset_here = dset_acc && (dset_idx == lkup_idx) && (dset_way == WAYBITS'(gi));

    assign rd_tag[gi]    = tag_mem[lkup_idx];
    assign eff_tag[gi]   = wr_here ? wr_tag : rd_tag[gi];
    assign eff_valid[gi] = wr_here ? 1'b1 : rd_valid[gi];
    assign eff_dirty[gi] = wr_here ? wr_dirty : (dset_here ? 1'b1 : rd_dirty[gi]);
    assign hit_vec[gi]   = eff_valid[gi] && (eff_tag[gi] == lkup_tag);
  end

  // Descending scans so that the lowest-numbered candidate is the last one assigned.
  always_comb begin
    look_hit     = |hit_vec;
    look_hit_way = '0;
    look_victim  = rr_eff;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        look_hit_way = WAYBITS'(w);
      end
      if (!eff_valid[w]) begin
        look_victim = WAYBITS'(w);
      end
    end
  end

  always_comb begin
    lkup_vld_d     = lkup_acc;
    hit_d          = hit_q;
    hit_way_d      = hit_way_q;
    victim_way_d   = victim_way_q;
    victim_valid_d = victim_valid_q;
    victim_dirty_d = victim_dirty_q;
    victim_tag_d   = victim_tag_q;
    if (lkup_acc) begin
      hit_d          = look_hit;
      hit_way_d      = look_hit_way;
      victim_way_d   = look_victim;
      victim_valid_d = eff_valid[look_victim];
      victim_dirty_d = eff_dirty[look_victim];
      victim_tag_d   = eff_tag[look_victim];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lkup_vld_q     <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      victim_way_q   <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
    end else begin
      lkup_vld_q     <= lkup_vld_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      victim_way_q   <= victim_way_d;
      victim_valid_q <= victim_valid_d;
      victim_dirty_q <= victim_dirty_d;
      victim_tag_q   <= victim_tag_d;
    end
  end

  assign lkup_vld     = lkup_vld_q;
  assign hit          = hit_q;
  assign hit_way      = hit_way_q;
  assign victim_way   = victim_way_q;
  assign victim_valid = victim_valid_q;
  assign victim_dirty = victim_dirty_q;
  assign victim_tag   = victim_tag_q;

endmodule

// File: tb/tb_tag_nway.sv
// Bench for tag_nway: directed cases with literal expectations, then a random phase.
// A behavioural model of sets/ways is compared against the DUT on every falling edge.
module tb_tag_nway;
  localparam int DRW  = 4;
  localparam int TW   = 15;
  localparam int WB   = 1;
  localparam int SETS = 1 << DRW;
  localparam int WAYS = 1 << WB;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lkup_en;
  logic [DRW-1:0] lkup_idx;
  logic [TW-1:0]  lkup_tag;
  logic           lkup_vld, hit, victim_valid, victim_dirty, busy;
  logic [WB-1:0]  hit_way, victim_way;
  logic [TW-1:0]  victim_tag;
  logic           wr_en;
  logic [DRW-1:0] wr_idx;
  logic [WB-1:0]  wr_way;
  logic [TW-1:0]  wr_tag;
  logic           wr_dirty;
  logic           dset_en;
  logic [DRW-1:0] dset_idx;
  logic [WB-1:0]  dset_way;
  logic           flush_req;

  int checks = 0;
  int errors = 0;

  tag_nway #(.DRWIDTH(DRW), .TAGW(TW), .WAYBITS(WB)) dut (
    .clk(clk), .rst_n(rst_n),
    .lkup_en(lkup_en), .lkup_idx(lkup_idx), .lkup_tag(lkup_tag),
    .lkup_vld(lkup_vld), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way), .wr_tag(wr_tag), .wr_dirty(wr_dirty),
    .dset_en(dset_en), .dset_idx(dset_idx), .dset_way(dset_way),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int  m_tag   [SETS][WAYS];
  bit  m_valid [SETS][WAYS];
  bit  m_dirty [SETS][WAYS];
  int  m_rr    [SETS];
  int  sweep_left = SETS;
  bit  e_vld = 0, e_hit = 0, e_vvalid = 0, e_vdirty = 0;
  int  e_hway = 0, e_vway = 0, e_vtag = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_left = SETS;
      e_vld = 0; e_hit = 0; e_vvalid = 0; e_vdirty = 0;
      e_hway = 0; e_vway = 0; e_vtag = 0;
    end else if (sweep_left > 0) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[SETS - sweep_left][w] = 0;
        m_dirty[SETS - sweep_left][w] = 0;
      end
      m_rr[SETS - sweep_left] = 0;
      sweep_left = sweep_left - 1;
      e_vld = 0;
    end else begin
      if (dset_en) m_dirty[dset_idx][dset_way] = 1;
      if (wr_en) begin
        m_tag[wr_idx][wr_way]   = int'(wr_tag);
        m_valid[wr_idx][wr_way] = 1;
        m_dirty[wr_idx][wr_way] = wr_dirty;
        m_rr[wr_idx]            = (int'(wr_way) + 1) % WAYS;
      end
      e_vld = lkup_en;
      if (lkup_en) begin
        int vw;
        e_hit = 0; e_hway = 0; vw = -1;
        for (int w = 0; w < WAYS; w++) begin
          if (!e_hit && m_valid[lkup_idx][w] && m_tag[lkup_idx][w] == int'(lkup_tag)) begin
            e_hit = 1; e_hway = w;
          end
          if (vw < 0 && !m_valid[lkup_idx][w]) vw = w;
        end
        if (vw < 0) vw = m_rr[lkup_idx];
        e_vway   = vw;
        e_vvalid = m_valid[lkup_idx][vw];
        e_vdirty = m_dirty[lkup_idx][vw];
        e_vtag   = m_tag[lkup_idx][vw];
      end
      if (flush_req) sweep_left = SETS;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model; tags of invalid victims carry no meaning.
  always @(negedge clk) begin
    chk("m_busy", 32'(busy), 32'(sweep_left != 0));
    chk("m_lkup_vld", 32'(lkup_vld), 32'(e_vld));
    chk("m_hit", 32'(hit), 32'(e_hit));
    chk("m_hit_way", 32'(hit_way), 32'(e_hway));
    chk("m_victim_way", 32'(victim_way), 32'(e_vway));
    chk("m_victim_valid", 32'(victim_valid), 32'(e_vvalid));
    chk("m_victim_dirty", 32'(victim_dirty), 32'(e_vdirty));
    if (e_vvalid) chk("m_victim_tag", 32'(victim_tag), 32'(e_vtag));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lkup_en = 0; wr_en = 0; dset_en = 0; flush_req = 0; wr_dirty = 0;
  endtask

  task automatic lookup(input int idx, input int tag);
    idle();
    lkup_en = 1; lkup_idx = DRW'(idx); lkup_tag = TW'(tag);
    cyc();
    idle();
  endtask

  task automatic fill(input int idx, input int way, input int tag, input bit d);
    idle();
    wr_en = 1; wr_idx = DRW'(idx); wr_way = WB'(way); wr_tag = TW'(tag); wr_dirty = d;
    cyc();
    idle();
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  initial begin
    int n;
    rst_n = 0;
    lkup_idx = '0; lkup_tag = '0; wr_idx = '0; wr_way = '0; wr_tag = '0;
    dset_idx = '0; dset_way = '0;
    idle();
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_lkup_vld", 32'(lkup_vld), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_victim_way", 32'(victim_way), 32'd0);
    rst_n = 1;
    count_busy("sweep_len");
    $display("txn reset sweep done");

    lookup(3, 'h123);
    chk("l3_vld", 32'(lkup_vld), 32'd1);
    chk("l3_hit", 32'(hit), 32'd0);
    chk("l3_vway", 32'(victim_way), 32'd0);
    chk("l3_vvalid", 32'(victim_valid), 32'd0);
    $display("txn lookup idx3 empty");

    fill(5, 0, 'h1A3, 0);
    lookup(5, 'h1A3);
    chk("l5a_vld", 32'(lkup_vld), 32'd1);
    chk("l5a_hit", 32'(hit), 32'd1);
    chk("l5a_hway", 32'(hit_way), 32'd0);
    chk("l5a_vway", 32'(victim_way), 32'd1);
    cyc();
    chk("l5a_vld_drop", 32'(lkup_vld), 32'd0);
    chk("l5a_hit_hold", 32'(hit), 32'd1);
    $display("txn fill/lookup idx5 way0");

    fill(5, 1, 'h022, 1);
    lookup(5, 'h7FF);
    chk("l5b_hit", 32'(hit), 32'd0);
    chk("l5b_hway", 32'(hit_way), 32'd0);
    chk("l5b_vway", 32'(victim_way), 32'd0);
    chk("l5b_vvalid", 32'(victim_valid), 32'd1);
    chk("l5b_vtag", 32'(victim_tag), 32'h1A3);
    chk("l5b_vdirty", 32'(victim_dirty), 32'd0);
    $display("txn fill idx5 way1 dirty, miss lookup");

    idle();
    wr_en = 1; wr_idx = 5; wr_way = 0; wr_tag = 'h055; wr_dirty = 0;
    dset_en = 1; dset_idx = 5; dset_way = 0;
    cyc();
    fill(5, 1, 'h022, 1);
    lookup(5, 'h055);
    chk("l5c_hit", 32'(hit), 32'd1);
    chk("l5c_hway", 32'(hit_way), 32'd0);
    chk("l5c_vway", 32'(victim_way), 32'd0);
    chk("l5c_vdirty", 32'(victim_dirty), 32'd0);
    chk("l5c_vtag", 32'(victim_tag), 32'h055);
    idle();
    dset_en = 1; dset_idx = 5; dset_way = 0;
    cyc();
    lookup(5, 'h055);
    chk("l5d_vdirty", 32'(victim_dirty), 32'd1);
    $display("txn wr vs dset collision and dirty set");

    idle();
    lkup_en = 1; lkup_idx = 7; lkup_tag = 'h0AA;
    wr_en = 1; wr_idx = 7; wr_way = 1; wr_tag = 'h0AA; wr_dirty = 0;
    cyc();
    idle();
    chk("l7_hit", 32'(hit), 32'd1);
    chk("l7_hway", 32'(hit_way), 32'd1);
    chk("l7_vway", 32'(victim_way), 32'd0);
    $display("txn write-first lookup idx7");

    idle();
    flush_req = 1; lkup_en = 1; lkup_idx = 5; lkup_tag = 'h1A3;
    cyc();
    flush_req = 0;
    chk("fl_first_vld", 32'(lkup_vld), 32'd1);
    n = 0;
    cyc();
    while (!lkup_vld && n < 100) begin
      n++;
      cyc();
    end
    chk("fl_vld_gap", 32'(n), 32'd16);
    chk("fl_hit", 32'(hit), 32'd0);
    chk("fl_vway", 32'(victim_way), 32'd0);
    chk("fl_vvalid", 32'(victim_valid), 32'd0);
    idle();
    $display("txn flush with lookup held");

    flush_req = 1;
    cyc();
    flush_req = 0;
    repeat (7) cyc();
    rst_n = 0;
    cyc();
    chk("mrst_busy", 32'(busy), 32'd1);
    chk("mrst_vld", 32'(lkup_vld), 32'd0);
    rst_n = 1;
    count_busy("mrst_sweep_len");
    $display("txn reset mid-sweep");

    for (int i = 0; i < 3000; i++) begin
      lkup_en   = ($urandom_range(0, 1) == 1);
      lkup_idx  = DRW'($urandom_range(0, SETS - 1));
      lkup_tag  = TW'($urandom_range(0, 3));
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_idx    = ($urandom_range(0, 1) == 1) ? lkup_idx : DRW'($urandom_range(0, SETS - 1));
      wr_way    = WB'($urandom_range(0, WAYS - 1));
      wr_tag    = TW'($urandom_range(0, 3));
      wr_dirty  = ($urandom_range(0, 1) == 1);
      dset_en   = ($urandom_range(0, 3) == 0);
      dset_idx  = ($urandom_range(0, 1) == 1) ? wr_idx : DRW'($urandom_range(0, SETS - 1));
      dset_way  = WB'($urandom_range(0, WAYS - 1));
      flush_req = ($urandom_range(0, 299) == 0);
      cyc();
    end
    idle();
    repeat (2) cyc();
    $display("txn random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
